// File: rtl/ex_result_demux_pkg.sv
// Shared EX-stage definitions: destination/operand select codes and the
// decode from a 4-bit select code to a channel index. The EX operand mux
// uses the same constants, so the two directions always agree on mapping.
package ex_result_demux_pkg;

    localparam int SEL_W = 4;
    localparam int CH_W  = 4;

    // Codes 0 and 1 both address channel A; 11..15 are unused.
    localparam logic [SEL_W-1:0] SEL_A     = 4'd0;
    localparam logic [SEL_W-1:0] SEL_A_ALT = 4'd1;
    localparam logic [SEL_W-1:0] SEL_B     = 4'd2;
    localparam logic [SEL_W-1:0] SEL_C     = 4'd3;
    localparam logic [SEL_W-1:0] SEL_D     = 4'd4;
    localparam logic [SEL_W-1:0] SEL_E     = 4'd5;
    localparam logic [SEL_W-1:0] SEL_F     = 4'd6;
    localparam logic [SEL_W-1:0] SEL_G     = 4'd7;
    localparam logic [SEL_W-1:0] SEL_H     = 4'd8;
    localparam logic [SEL_W-1:0] SEL_I     = 4'd9;
    localparam logic [SEL_W-1:0] SEL_J     = 4'd10;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
    } sel_dec_t;

    function automatic sel_dec_t sel_to_ch(input logic [SEL_W-1:0] sel);
        sel_dec_t d;
        d.valid = 1'b1;
        d.ch    = '0;
        case (sel)
            SEL_A, SEL_A_ALT: d.ch = 4'd0;
            SEL_B:            d.ch = 4'd1;
            SEL_C:            d.ch = 4'd2;
            SEL_D:            d.ch = 4'd3;
            SEL_E:            d.ch = 4'd4;
            SEL_F:            d.ch = 4'd5;
            SEL_G:            d.ch = 4'd6;
            SEL_H:            d.ch = 4'd7;
            SEL_I:            d.ch = 4'd8;
            SEL_J:            d.ch = 4'd9;
            default:          d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ex_result_demux_fifo.sv
// Small in-order buffer, DEPTH x W, with occupancy.
//   clk, rst_n       clock / async active-low reset
//   push, wdata      write at tail (ignored when full)
//   pop              advance head (ignored when empty)
//   rdata            head entry straight from storage; when empty it holds
//                    the last entry popped (zero after reset)
//   occupancy        entries held, 0..DEPTH
//   full, empty      status derived from occupancy
module ex_result_demux_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [W-1:0]  hold;
    logic          do_push, do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Last popped entry keeps the shared bus stable while the buffer is empty.
    assign rdata     = empty ? hold : mem[rd_ptr];
    assign occupancy = count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                hold   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ex_result_demux.sv
// EX result router: one tagged value in, delivered to one of NUM_CH channels.
//   clk, rst_n            clock / async active-low reset
//   in_valid/in_ready     upstream handshake; in_ready depends on state only
//   in_data, in_sel       value and 4-bit destination code
//   out_data              shared bus, head of buffer
//   out_valid[NUM_CH]     one-hot owner of out_data, zero when empty
//   out_ready[NUM_CH]     per-channel accept; only the owner's bit matters
//   err_pulse             one cycle after a bad code was accepted
//   err_count             saturating count of dropped bad-code transfers
//   occupancy             entries buffered
module ex_result_demux
    import ex_result_demux_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 10,
    parameter int DEPTH  = 2,
    parameter int ERR_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [DATA_W-1:0]       out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic                    err_pulse,
    output logic [ERR_W-1:0]        err_count,
    output logic [$clog2(DEPTH):0]  occupancy
);
    localparam int EW = DATA_W + CH_W;
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    sel_dec_t         dec;
    logic             push, store, bad, pop;
    logic             full, empty;
    logic [EW-1:0]    head;
    logic [CH_W-1:0]  head_ch;

    assign dec      = sel_to_ch(in_sel);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    // Bad codes are accepted and dropped so upstream never stalls on them.
    assign store    = push && dec.valid;
    assign bad      = push && !dec.valid;

    ex_result_demux_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (store),
        .wdata     ({dec.ch, in_data}),
        .pop       (pop),
        .rdata     (head),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    assign head_ch  = head[DATA_W +: CH_W];
    assign out_data = head[DATA_W-1:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign out_valid[c] = !empty && (head_ch == CH_W'(c));
    end

    // Non-owner ready bits are masked off by out_valid.
    assign pop = |(out_valid & out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= bad;
            if (bad && (err_count != '1)) err_count <= err_count + ERR_ONE;
        end
    end

endmodule

// File: tb/tb_ex_result_demux.sv
module tb_ex_result_demux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_sel;
    logic [31:0] out_data;
    logic [9:0]  out_valid;
    logic [9:0]  out_ready;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic [1:0]  occupancy;

    ex_result_demux dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic exp_pulse = 1'b0;
    int   exp_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [3:0] s, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    // Compare every output to the model at the negedge, then advance the
    // model by what the upcoming posedge will do, then clock.
    task automatic tick();
        logic [9:0] ev;
        bit         popq, acc, good;
        int         ch;
        ev = '0;
        if (q.size() != 0) ev[q[0].ch] = 1'b1;
        chk("out_valid", 64'(out_valid), 64'(ev));
        if (q.size() != 0) chk("out_data", 64'(out_data), 64'(q[0].data));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("err_pulse", 64'(err_pulse), 64'(exp_pulse));
        chk("err_count", 64'(err_count), 64'(exp_cnt));

        popq = (q.size() != 0) && (out_ready[q[0].ch] === 1'b1);
        acc  = (in_valid === 1'b1) && (q.size() < 2);
        good = (in_sel <= 4'd10);
        ch   = (in_sel <= 4'd1) ? 0 : int'(in_sel) - 1;
        exp_pulse = acc && !good;
        if (exp_pulse && exp_cnt != 255) exp_cnt++;
        if (popq) void'(q.pop_front());
        if (acc && good) q.push_back('{ch: ch, data: in_data});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = '0;
        drv(1'b0, 4'd0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and idle
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        tick(); tick();

        // Single transfer, latency one cycle
        out_ready = '1;
        drv(1'b1, 4'd0, 32'hDEAD_BEEF);
        tick();
        drv(1'b0, 4'd0, 32'h0);
        chk("lat_valid", 64'(out_valid), 64'h001);
        chk("lat_data", 64'(out_data), 64'hDEAD_BEEF);
        tick(); tick();

        // sel 1 then sel 10 back to back
        drv(1'b1, 4'd1, 32'hA1);
        tick();
        drv(1'b1, 4'd10, 32'hA2);
        tick();
        drv(1'b0, 4'd0, 32'h0);
        chk("ord_ch9", 64'(out_valid), 64'h200);
        tick(); tick();

        // Streaming every valid code with all channels ready
        for (int s = 0; s <= 10; s++) begin
            drv(1'b1, 4'(s), $urandom);
            tick();
        end
        drv(1'b0, 4'd0, 32'h0);
        tick(); tick();

        // Fill to full with no consumer ready
        out_ready = '0;
        drv(1'b1, 4'd3, 32'hC0);
        tick();
        drv(1'b1, 4'd5, 32'hC1);
        tick();
        drv(1'b1, 4'd7, 32'hC2);
        tick();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_occ", 64'(occupancy), 64'd2);
        tick();
        // Only the head owner's ready (ch2) frees a slot; push still blocked
        out_ready = 10'b00_0000_0100;
        tick();
        chk("drain_in_ready", 64'(in_ready), 64'd1);
        out_ready = 10'b00_0000_0001;
        tick();
        drv(1'b0, 4'd0, 32'h0);
        tick();
        out_ready = '1;
        tick(); tick(); tick();

        // Bad select: dropped, pulse, count
        drv(1'b1, 4'd13, 32'h1234);
        tick();
        drv(1'b0, 4'd0, 32'h0);
        chk("bad_pulse", 64'(err_pulse), 64'd1);
        chk("bad_count", 64'(err_count), 64'd1);
        tick(); tick();
        for (int i = 0; i < 300; i++) begin
            drv(1'b1, 4'(11 + (i % 5)), 32'(i));
            tick();
        end
        drv(1'b0, 4'd0, 32'h0);
        tick();
        chk("sat_count", 64'(err_count), 64'hFF);

        // Random mix of codes and ready patterns
        for (int i = 0; i < 60; i++) begin
            out_ready = 10'($urandom);
            drv(1'($urandom), 4'($urandom_range(0, 15)), $urandom);
            tick();
        end
        drv(1'b0, 4'd0, 32'h0);
        out_ready = '1;
        tick(); tick(); tick();

        // Asynchronous reset while full with head on channel 2
        out_ready = '0;
        drv(1'b1, 4'd3, 32'hE0);
        tick();
        drv(1'b1, 4'd4, 32'hE1);
        tick();
        drv(1'b0, 4'd0, 32'h0);
        chk("pre_rst_valid", 64'(out_valid), 64'h004);
        chk("pre_rst_occ", 64'(occupancy), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'h000);
        chk("arst_occ", 64'(occupancy), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        chk("arst_err", 64'(err_count), 64'd0);
        chk("arst_pulse", 64'(err_pulse), 64'd0);
        q.delete();
        exp_pulse = 1'b0;
        exp_cnt   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = '1;
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
